ext_ex_dm_stage: RTL and testbench

- Pipeline register between the extension ALU (integer multiply, FP add/sub/mul, int/float conversion) and the data-memory stage.
- Captures the ALU result, its destination register tag and its ov/zr/neg flags.
- Holds them in a 2-entry skid buffer under a valid/ready handshake so a DM-side stall never drops an in-flight result.
- Maintains the architectural flag register with per-function update rules, and supports a pipeline flush.

---
 rtl/ext_ex_dm_stage_if.sv | 27 ++
 rtl/ext_ex_dm_stage.sv | 55 +++++
 tb/tb_ext_ex_dm_stage.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ext_ex_dm_stage_if.sv
// ext_ex_dm_stage_if: EX-to-DM result handshake bundle
interface ext_ex_dm_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_func;
  logic [DW-1:0] in_data;
  logic [RW-1:0] in_rd;
  logic          in_ov;
  logic          in_zr;
  logic          in_neg;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [RW-1:0] out_rd;
  logic          out_we;
  modport master (
    output in_valid, in_func, in_data, in_rd, in_ov, in_zr, in_neg, out_ready,
    input  in_ready, out_valid, out_data, out_rd, out_we
  );
  modport slave (
    input  in_valid, in_func, in_data, in_rd, in_ov, in_zr, in_neg, out_ready,
    output in_ready, out_valid, out_data, out_rd, out_we
  );
endinterface

// File: rtl/ext_ex_dm_stage.sv
// ext_ex_dm_stage: EX-to-DM skid-buffered pipeline register with architectural flag register
module ext_ex_dm_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  ext_ex_dm_stage_if.slave     bus,
  output logic [2:0]           flags,
  output logic                 illegal_op
);
  localparam int PW = DW + RW + 1;
  logic          main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic [PW-1:0] main_q, main_d, skid_q, skid_d, in_p;
  logic [2:0]    flags_q, flags_d;
  logic          illegal_q, illegal_d;
  logic          acc, drain, to_main, bad;
  always_comb begin
    bad          = bus.in_func == 3'b111;
    in_p         = {!bad, bus.in_rd, bus.in_data};
    acc          = bus.in_valid && !skid_valid_q && !flush;
    drain        = main_valid_q && bus.out_ready;
    to_main      = acc && (!main_valid_q || drain);
    main_valid_d = !flush && (to_main || (drain ? skid_valid_q : main_valid_q));
    main_d       = to_main ? in_p : (drain && skid_valid_q) ? skid_q : main_q;
    skid_valid_d = !flush && ((acc && !to_main) || (skid_valid_q && !drain));
    skid_d       = (acc && !to_main) ? in_p : skid_q;
    flags_d      = (!acc || bad) ? flags_q
                                 : {bus.in_func != 3'b101 && bus.in_ov, bus.in_zr, bus.in_neg};
    illegal_d    = acc && bad;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
      flags_q      <= 3'b000;
      illegal_q    <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      flags_q      <= flags_d;
      illegal_q    <= illegal_d;
    end
  end
  assign bus.in_ready                         = !skid_valid_q;
  assign bus.out_valid                        = main_valid_q;
  assign {bus.out_we, bus.out_rd, bus.out_data} = main_q;
  assign flags                                = flags_q;
  assign illegal_op                           = illegal_q;
endmodule

// File: tb/tb_ext_ex_dm_stage.sv
// tb_ext_ex_dm_stage: directed self-checking bench for ext_ex_dm_stage
module tb_ext_ex_dm_stage;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] flags;
  logic       illegal_op;
  int         n_cmp = 0;
  int         n_bad = 0;
  ext_ex_dm_stage_if #(.DW(32), .RW(5)) bus ();
  ext_ex_dm_stage #(.DW(32), .RW(5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus(bus),
    .flags(flags),
    .illegal_op(illegal_op)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [2:0] f, input logic [31:0] d, input logic [4:0] rd,
                       input logic ov, input logic zr, input logic neg);
    bus.in_valid = v;
    bus.in_func  = f;
    bus.in_data  = d;
    bus.in_rd    = rd;
    bus.in_ov    = ov;
    bus.in_zr    = zr;
    bus.in_neg   = neg;
  endtask
  initial begin
    drive(0, 3'b000, 32'h0, 5'd0, 0, 0, 0);
    bus.out_ready = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_flags", flags, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_we", bus.out_we, 0);
    chk("rst_illegal", illegal_op, 0);
    step();
    rst_n = 1'b1;
    step();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1, 3'b010, 32'h3F80_0000 + i, 5'(i), 0, 0, 0);
      step();
      chk("stream_valid", bus.out_valid, 1);
      chk("stream_data", bus.out_data, 32'h3F80_0000 + i);
      chk("stream_rd", bus.out_rd, i);
      chk("stream_in_ready", bus.in_ready, 1);
    end
    drive(0, 3'b010, 32'h0, 5'd0, 0, 0, 0);
    step();
    chk("stream_end_valid", bus.out_valid, 0);
    bus.out_ready = 1'b0;
    drive(1, 3'b000, 32'hAAAA_0001, 5'd1, 0, 0, 0);
    step();
    chk("bp_a_main", bus.out_data, 32'hAAAA_0001);
    chk("bp_a_in_ready", bus.in_ready, 1);
    drive(1, 3'b000, 32'hBBBB_0002, 5'd2, 0, 0, 0);
    step();
    chk("bp_b_in_ready", bus.in_ready, 0);
    chk("bp_b_hold_data", bus.out_data, 32'hAAAA_0001);
    drive(1, 3'b000, 32'hCCCC_0003, 5'd3, 0, 0, 0);
    step();
    chk("bp_c_hold_data", bus.out_data, 32'hAAAA_0001);
    chk("bp_c_hold_rd", bus.out_rd, 1);
    chk("bp_c_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    step();
    chk("bp_rel_b", bus.out_data, 32'hBBBB_0002);
    chk("bp_rel_in_ready", bus.in_ready, 1);
    step();
    chk("bp_rel_c", bus.out_data, 32'hCCCC_0003);
    chk("bp_rel_c_valid", bus.out_valid, 1);
    drive(0, 3'b000, 32'h0, 5'd0, 0, 0, 0);
    step();
    chk("bp_empty", bus.out_valid, 0);
    drive(1, 3'b011, 32'h1111_0000, 5'd4, 1, 0, 1);
    step();
    chk("flags_subf", flags, 3'b101);
    drive(1, 3'b101, 32'h2222_0000, 5'd5, 1, 1, 0);
    step();
    chk("flags_itf", flags, 3'b010);
    chk("itf_we", bus.out_we, 1);
    drive(1, 3'b111, 32'h3333_0000, 5'd6, 1, 0, 1);
    step();
    chk("flags_ill_hold", flags, 3'b010);
    chk("ill_pulse", illegal_op, 1);
    chk("ill_we", bus.out_we, 0);
    chk("ill_valid", bus.out_valid, 1);
    drive(0, 3'b000, 32'h0, 5'd0, 0, 0, 0);
    step();
    chk("ill_pulse_end", illegal_op, 0);
    bus.out_ready = 1'b0;
    drive(1, 3'b000, 32'h4444_0000, 5'd7, 0, 1, 0);
    step();
    drive(1, 3'b001, 32'h5555_0000, 5'd8, 0, 1, 0);
    step();
    chk("fl_full", bus.in_ready, 0);
    flush = 1'b1;
    drive(1, 3'b100, 32'h6666_0000, 5'd9, 1, 1, 1);
    step();
    flush = 1'b0;
    drive(0, 3'b000, 32'h0, 5'd0, 0, 0, 0);
    chk("fl_out_valid", bus.out_valid, 0);
    chk("fl_in_ready", bus.in_ready, 1);
    chk("fl_flags", flags, 3'b010);
    chk("fl_illegal", illegal_op, 0);
    flush = 1'b1;
    drive(1, 3'b111, 32'h7777_0000, 5'd10, 1, 1, 1);
    step();
    flush = 1'b0;
    drive(0, 3'b000, 32'h0, 5'd0, 0, 0, 0);
    chk("fl_ill_suppressed", illegal_op, 0);
    chk("fl_ill_valid", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    drive(1, 3'b000, 32'h8888_0000, 5'd11, 0, 0, 0);
    step();
    chk("sim_x", bus.out_data, 32'h8888_0000);
    drive(1, 3'b000, 32'h9999_0000, 5'd12, 0, 0, 0);
    step();
    chk("sim_y", bus.out_data, 32'h9999_0000);
    chk("sim_in_ready", bus.in_ready, 1);
    drive(0, 3'b000, 32'h0, 5'd0, 0, 0, 0);
    step();
    chk("sim_skid_empty", bus.out_valid, 0);
    bus.out_ready = 1'b0;
    drive(1, 3'b000, 32'hDDDD_0000, 5'd13, 0, 0, 1);
    step();
    step();
    chk("rm_full", bus.in_ready, 0);
    chk("rm_flags", flags, 3'b001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm_out_valid", bus.out_valid, 0);
    chk("rm_in_ready", bus.in_ready, 1);
    chk("rm_flags_clr", flags, 3'b000);
    drive(0, 3'b000, 32'h0, 5'd0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rm_post_valid", bus.out_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
